// File: rtl/encounter_compositor.sv
// Encounter compositor: per-pixel sprite compositing plus the lives/score/
// invulnerability game state machine, advanced once per frame at pixel (0,0).
module encounter_compositor #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned FLASH_FRAMES = 60,
  parameter logic [11:0] BG_COLOR     = 12'hFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] display_col,
  input  logic [10:0] display_row,
  input  logic        visible,
  input  logic [3:0]  plyr_red,
  input  logic [3:0]  plyr_green,
  input  logic [3:0]  plyr_blue,
  input  logic        plyr_visible,
  input  logic [3:0]  enc1_red,
  input  logic [3:0]  enc1_green,
  input  logic [3:0]  enc1_blue,
  input  logic        enc1_visible,
  input  logic [3:0]  enc2_red,
  input  logic [3:0]  enc2_green,
  input  logic [3:0]  enc2_blue,
  input  logic        enc2_visible,
  input  logic        restart,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic        game_over
);

  localparam int unsigned LIVES_W = 3;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned FLASH_W = 8;
  localparam int unsigned COLOR_W = 12;

  typedef enum logic [1:0] {
    ST_PLAYING   = 2'd0,
    ST_HIT_FLASH = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  state_t               r_state;
  logic [LIVES_W-1:0]   r_lives;
  logic [SCORE_W-1:0]   r_score;
  logic [FLASH_W-1:0]   r_flash_cnt;
  logic                 r_hit_pending;
  logic                 r_game_over;
  logic [COLOR_W-1:0]   r_pixel;

  state_t               w_state_nxt;
  logic [LIVES_W-1:0]   w_lives_nxt;
  logic [SCORE_W-1:0]   w_score_nxt;
  logic [FLASH_W-1:0]   w_flash_nxt;
  logic                 w_hit_nxt;
  logic [COLOR_W-1:0]   w_pixel_nxt;

  logic                 w_fs;
  logic                 w_coll;
  logic                 w_plyr_drawn;
  logic [COLOR_W-1:0]   w_plyr_color;
  logic [COLOR_W-1:0]   w_enc1_color;
  logic [COLOR_W-1:0]   w_enc2_color;

  assign w_fs         = (display_col == 12'd0) && (display_row == 11'd0);
  // Collision uses the raw player mask so a blinking player still collides.
  assign w_coll       = visible && plyr_visible && (enc1_visible || enc2_visible);
  assign w_plyr_drawn = plyr_visible && !((r_state == ST_HIT_FLASH) && r_flash_cnt[3]);
  assign w_plyr_color = {plyr_blue, plyr_green, plyr_red};
  assign w_enc1_color = {enc1_blue, enc1_green, enc1_red};
  assign w_enc2_color = {enc2_blue, enc2_green, enc2_red};

  // Game state next-state logic; frame decisions happen only on the frame-start pixel.
  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_score_nxt = r_score;
    w_flash_nxt = r_flash_cnt;
    w_hit_nxt   = r_hit_pending;
    unique case (r_state)
      ST_PLAYING: begin
        if (w_fs) begin
          if (r_hit_pending) begin
            if (r_lives <= LIVES_W'(1)) begin
              w_lives_nxt = '0;
              w_state_nxt = ST_GAME_OVER;
            end else begin
              w_lives_nxt = r_lives - LIVES_W'(1);
              w_flash_nxt = FLASH_W'(FLASH_FRAMES);
              w_state_nxt = ST_HIT_FLASH;
            end
          end else if (r_score != {SCORE_W{1'b1}}) begin
            w_score_nxt = r_score + SCORE_W'(1);
          end
          // A collision on the frame-start pixel belongs to the new frame.
          w_hit_nxt = w_coll;
        end else if (w_coll) begin
          w_hit_nxt = 1'b1;
        end
      end
      ST_HIT_FLASH: begin
        w_hit_nxt = 1'b0;
        if (w_fs) begin
          w_flash_nxt = r_flash_cnt - FLASH_W'(1);
          if (r_flash_cnt <= FLASH_W'(1)) begin
            w_flash_nxt = '0;
            w_state_nxt = ST_PLAYING;
          end
        end
      end
      ST_GAME_OVER: begin
        w_hit_nxt = 1'b0;
        if (restart) begin
          w_state_nxt = ST_PLAYING;
          w_lives_nxt = LIVES_W'(LIVES);
          w_score_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_PLAYING;
        w_hit_nxt   = 1'b0;
      end
    endcase
  end

  // Pixel priority: blank outside active video, red-only palette in game over.
  always_comb begin
    w_pixel_nxt = '0;
    if (visible) begin
      if (r_state == ST_GAME_OVER) begin
        w_pixel_nxt = plyr_visible ? {8'h00, plyr_red} : {8'h00, BG_COLOR[3:0]};
      end else if (w_plyr_drawn) begin
        w_pixel_nxt = w_plyr_color;
      end else if (enc1_visible) begin
        w_pixel_nxt = w_enc1_color;
      end else if (enc2_visible) begin
        w_pixel_nxt = w_enc2_color;
      end else begin
        w_pixel_nxt = BG_COLOR;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_PLAYING;
      r_lives       <= LIVES_W'(LIVES);
      r_score       <= '0;
      r_flash_cnt   <= '0;
      r_hit_pending <= 1'b0;
      r_game_over   <= 1'b0;
      r_pixel       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_lives       <= w_lives_nxt;
      r_score       <= w_score_nxt;
      r_flash_cnt   <= w_flash_nxt;
      r_hit_pending <= w_hit_nxt;
      r_game_over   <= (w_state_nxt == ST_GAME_OVER);
      r_pixel       <= w_pixel_nxt;
    end
  end

  assign vga_blue  = r_pixel[11:8];
  assign vga_green = r_pixel[7:4];
  assign vga_red   = r_pixel[3:0];
  assign lives     = r_lives;
  assign score     = r_score;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_encounter_compositor.sv
// Directed bench for encounter_compositor: compositing, hits, flash, game over, saturation.
module tb_encounter_compositor;

  localparam logic [11:0] P_COL  = 12'hABC;
  localparam logic [11:0] E1_COL = 12'h123;
  localparam logic [11:0] E2_COL = 12'h456;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        visible;
  logic [3:0]  plyr_red, plyr_green, plyr_blue;
  logic        plyr_visible;
  logic [3:0]  enc1_red, enc1_green, enc1_blue;
  logic        enc1_visible;
  logic [3:0]  enc2_red, enc2_green, enc2_blue;
  logic        enc2_visible;
  logic        restart;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic [2:0]  lives;
  logic [15:0] score;
  logic        game_over;

  int n_checks = 0;
  int n_fail   = 0;

  encounter_compositor dut (
    .clock(clock), .reset(reset),
    .display_col(display_col), .display_row(display_row), .visible(visible),
    .plyr_red(plyr_red), .plyr_green(plyr_green), .plyr_blue(plyr_blue),
    .plyr_visible(plyr_visible),
    .enc1_red(enc1_red), .enc1_green(enc1_green), .enc1_blue(enc1_blue),
    .enc1_visible(enc1_visible),
    .enc2_red(enc2_red), .enc2_green(enc2_green), .enc2_blue(enc2_blue),
    .enc2_visible(enc2_visible),
    .restart(restart),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .lives(lives), .score(score), .game_over(game_over)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] vga_rgb();
    return {vga_blue, vga_green, vga_red};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_px(input logic [11:0] col, input logic [10:0] row, input logic vis,
                        input logic pv, input logic [11:0] pc,
                        input logic e1v, input logic [11:0] e1c,
                        input logic e2v, input logic [11:0] e2c);
    display_col  = col;
    display_row  = row;
    visible      = vis;
    plyr_visible = pv;
    {plyr_blue, plyr_green, plyr_red} = pc;
    enc1_visible = e1v;
    {enc1_blue, enc1_green, enc1_red} = e1c;
    enc2_visible = e2v;
    {enc2_blue, enc2_green, enc2_red} = e2c;
  endtask

  task automatic set_idle();
    set_px(12'd1, 11'd1, 1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 12'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_idle();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // One frame: frame-start pixel, then 24 pixels, the first ncoll of them colliding.
  task automatic frame(input int ncoll, input bit fs_coll, output logic [11:0] first_px);
    set_px(12'd0, 11'd0, 1'b1, fs_coll, P_COL, fs_coll, E1_COL, 1'b0, 12'h0);
    tick();
    first_px = 12'h000;
    for (int i = 0; i < 24; i++) begin
      if (i < ncoll)
        set_px(12'(10 + i), 11'd5, 1'b1, 1'b1, P_COL, 1'b1, E1_COL, 1'b0, 12'h0);
      else
        set_px(12'(10 + i), 11'd5, 1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 12'h0);
      tick();
      if (i == 0) first_px = vga_rgb();
    end
    set_idle();
  endtask

  task automatic test_reset();
    n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", lives); end
    n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    n_checks++; if (vga_rgb() !== 12'h000) begin n_fail++; $display("FAIL reset_vga: got %h want 000", vga_rgb()); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_pixel();
    set_px(12'd100, 11'd50, 1'b1, 1'b1, P_COL, 1'b0, 12'h0, 1'b0, 12'h0);
    tick();
    n_checks++; if (vga_rgb() !== 12'hABC) begin n_fail++; $display("FAIL px_player: got %h want abc", vga_rgb()); end
    set_px(12'd101, 11'd50, 1'b1, 1'b0, 12'h0, 1'b1, E1_COL, 1'b0, 12'h0);
    #2;
    n_checks++; if (vga_rgb() !== 12'hABC) begin n_fail++; $display("FAIL px_latency: got %h want abc", vga_rgb()); end
    tick();
    n_checks++; if (vga_rgb() !== 12'h123) begin n_fail++; $display("FAIL px_enc1: got %h want 123", vga_rgb()); end
    set_px(12'd102, 11'd50, 1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b1, E2_COL);
    tick();
    n_checks++; if (vga_rgb() !== 12'h456) begin n_fail++; $display("FAIL px_enc2: got %h want 456", vga_rgb()); end
    set_px(12'd103, 11'd50, 1'b1, 1'b0, 12'h0, 1'b1, E1_COL, 1'b1, E2_COL);
    tick();
    n_checks++; if (vga_rgb() !== 12'h123) begin n_fail++; $display("FAIL px_enc1_over_enc2: got %h want 123", vga_rgb()); end
    set_px(12'd104, 11'd50, 1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 12'h0);
    tick();
    n_checks++; if (vga_rgb() !== 12'hFFF) begin n_fail++; $display("FAIL px_background: got %h want fff", vga_rgb()); end
    set_px(12'd100, 11'd50, 1'b0, 1'b1, P_COL, 1'b0, 12'h0, 1'b0, 12'h0);
    tick();
    n_checks++; if (vga_rgb() !== 12'h000) begin n_fail++; $display("FAIL px_blank: got %h want 000", vga_rgb()); end
    set_px(12'd105, 11'd50, 1'b1, 1'b1, P_COL, 1'b1, E1_COL, 1'b1, E2_COL);
    tick();
    n_checks++; if (vga_rgb() !== 12'hABC) begin n_fail++; $display("FAIL px_player_over_enc: got %h want abc", vga_rgb()); end
    do_reset();
  endtask

  task automatic test_hit();
    logic [11:0] px;
    frame(0, 1'b0, px);
    n_checks++; if (score !== 16'd1) begin n_fail++; $display("FAIL hit_score_first: got %0d want 1", score); end
    frame(20, 1'b0, px);
    n_checks++; if (px !== 12'hABC) begin n_fail++; $display("FAIL hit_coll_px: got %h want abc", px); end
    n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL hit_lives_before: got %0d want 3", lives); end
    frame(0, 1'b0, px);
    n_checks++; if (lives !== 3'd2) begin n_fail++; $display("FAIL hit_lives: got %0d want 2", lives); end
    n_checks++; if (score !== 16'd2) begin n_fail++; $display("FAIL hit_score: got %0d want 2", score); end
    n_checks++; if (dut.r_flash_cnt !== 8'd60) begin n_fail++; $display("FAIL hit_flash_cnt: got %0d want 60", dut.r_flash_cnt); end
    set_px(12'd50, 11'd5, 1'b1, 1'b1, P_COL, 1'b0, 12'h0, 1'b0, 12'h0);
    tick();
    n_checks++; if (vga_rgb() !== 12'hFFF) begin n_fail++; $display("FAIL hit_blink_hidden: got %h want fff", vga_rgb()); end
    set_idle();
  endtask

  task automatic test_flash_immunity();
    logic [11:0] px;
    for (int i = 1; i <= 60; i++) begin
      frame(20, 1'b0, px);
      n_checks++; if (lives !== 3'd2) begin n_fail++; $display("FAIL flash_lives_%0d: got %0d want 2", i, lives); end
      if (i == 1) begin
        n_checks++; if (px !== 12'h123) begin n_fail++; $display("FAIL flash_blink_off: got %h want 123", px); end
      end
      if (i == 5) begin
        n_checks++; if (px !== 12'hABC) begin n_fail++; $display("FAIL flash_blink_on: got %h want abc", px); end
      end
    end
    n_checks++; if (score !== 16'd2) begin n_fail++; $display("FAIL flash_score: got %0d want 2", score); end
    n_checks++; if (dut.r_flash_cnt !== 8'd0) begin n_fail++; $display("FAIL flash_cnt_end: got %0d want 0", dut.r_flash_cnt); end
    frame(0, 1'b0, px);
    n_checks++; if (lives !== 3'd1) begin n_fail++; $display("FAIL flash_second_hit: got %0d want 1", lives); end
    n_checks++; if (score !== 16'd2) begin n_fail++; $display("FAIL flash_second_score: got %0d want 2", score); end
  endtask

  task automatic test_game_over();
    logic [11:0] px;
    repeat (60) frame(0, 1'b0, px);
    frame(20, 1'b0, px);
    n_checks++; if (score !== 16'd3) begin n_fail++; $display("FAIL go_score_pre: got %0d want 3", score); end
    frame(0, 1'b0, px);
    n_checks++; if (lives !== 3'd0) begin n_fail++; $display("FAIL go_lives: got %0d want 0", lives); end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL go_flag: got %b want 1", game_over); end
    set_px(12'd60, 11'd5, 1'b1, 1'b0, 12'h0, 1'b1, E1_COL, 1'b0, 12'h0);
    tick();
    n_checks++; if (vga_rgb() !== 12'h00F) begin n_fail++; $display("FAIL go_enc_suppressed: got %h want 00f", vga_rgb()); end
    set_px(12'd61, 11'd5, 1'b1, 1'b1, P_COL, 1'b1, E1_COL, 1'b0, 12'h0);
    tick();
    n_checks++; if (vga_rgb() !== 12'h00C) begin n_fail++; $display("FAIL go_player_red: got %h want 00c", vga_rgb()); end
    repeat (2) frame(20, 1'b0, px);
    n_checks++; if (score !== 16'd3) begin n_fail++; $display("FAIL go_score_frozen: got %0d want 3", score); end
    n_checks++; if (lives !== 3'd0) begin n_fail++; $display("FAIL go_lives_frozen: got %0d want 0", lives); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL restart_lives: got %0d want 3", lives); end
    n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL restart_score: got %0d want 0", score); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL restart_flag: got %b want 0", game_over); end
    frame(0, 1'b0, px);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_checks++; if (score !== 16'd1) begin n_fail++; $display("FAIL restart_ignored: got %0d want 1", score); end
    frame(0, 1'b0, px);
    n_checks++; if (score !== 16'd2) begin n_fail++; $display("FAIL restart_ignored_next: got %0d want 2", score); end
  endtask

  task automatic test_fs_collision();
    logic [11:0] px;
    do_reset();
    frame(0, 1'b0, px);
    frame(0, 1'b1, px);
    n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL fsc_no_loss: got %0d want 3", lives); end
    n_checks++; if (score !== 16'd2) begin n_fail++; $display("FAIL fsc_score: got %0d want 2", score); end
    frame(0, 1'b0, px);
    n_checks++; if (lives !== 3'd2) begin n_fail++; $display("FAIL fsc_loss_next: got %0d want 2", lives); end
    repeat (3) frame(0, 1'b0, px);
    set_px(12'd40, 11'd5, 1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 12'h0);
    tick();
    reset = 1'b0;
    #2;
    n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL midreset_lives: got %0d want 3", lives); end
    n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL midreset_score: got %0d want 0", score); end
    n_checks++; if (vga_rgb() !== 12'h000) begin n_fail++; $display("FAIL midreset_vga: got %h want 000", vga_rgb()); end
    n_checks++; if (dut.r_flash_cnt !== 8'd0) begin n_fail++; $display("FAIL midreset_flash: got %0d want 0", dut.r_flash_cnt); end
    tick();
    reset = 1'b1;
    tick();
    frame(0, 1'b0, px);
    n_checks++; if (score !== 16'd1) begin n_fail++; $display("FAIL postreset_score: got %0d want 1", score); end
    n_checks++; if (lives !== 3'd3) begin n_fail++; $display("FAIL postreset_lives: got %0d want 3", lives); end
  endtask

  task automatic test_saturation();
    force dut.r_score = 16'hFFFD;
    #1;
    release dut.r_score;
    set_px(12'd0, 11'd0, 1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 1'b0, 12'h0);
    tick();
    n_checks++; if (score !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe: got %h want fffe", score); end
    tick();
    n_checks++; if (score !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff: got %h want ffff", score); end
    tick();
    n_checks++; if (score !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold1: got %h want ffff", score); end
    tick();
    n_checks++; if (score !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold2: got %h want ffff", score); end
    set_idle();
  endtask

  initial begin
    reset   = 1'b0;
    restart = 1'b0;
    set_idle();
    tick();
    tick();
    test_reset();
    test_pixel();
    test_hit();
    test_flash_immunity();
    test_game_over();
    test_fs_collision();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encounter_compositor.md
ENCOUNTER_COMPOSITOR -- requirements
Module: encounter_compositor

Interface
REQ-001 Parameter LIVES, default 3, lives loaded on reset and on restart (1..7).
REQ-002 Parameter FLASH_FRAMES, default 60, invulnerability length in frames (1..255).
REQ-003 Parameter BG_COLOR, default 12'hFFF, background pixel {blue,green,red} 4 bits each.
REQ-004 clock  in  1  pixel clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (reset==0 resets).
REQ-006 display_col  in  12  current pixel column.
REQ-007 display_row  in  11  current pixel row.
REQ-008 visible  in  1  pixel inside active video area.
REQ-009 plyr_red, plyr_green, plyr_blue  in  4 each  player sprite colour.
REQ-010 plyr_visible  in  1  player sprite opaque at this pixel.
REQ-011 enc1_red, enc1_green, enc1_blue, enc1_visible  in  4/4/4/1  encounter 1 sprite.
REQ-012 enc2_red, enc2_green, enc2_blue, enc2_visible  in  4/4/4/1  encounter 2 sprite.
REQ-013 restart  in  1  single-cycle pulse, leaves GAME_OVER.
REQ-014 vga_red, vga_green, vga_blue  out  4 each  composited pixel, registered.
REQ-015 lives  out  3  remaining lives.
REQ-016 score  out  16  frames survived, saturating.
REQ-017 game_over  out  1  high in GAME_OVER state.

Function
REQ-018 Frame start (FS) SHALL be the cycle where display_col==0 and display_row==0.
REQ-019 Pixel output SHALL have 1-cycle latency: inputs sampled at edge N appear on vga_* after edge N.
REQ-020 Priority: visible==0 -> 0x000; else player (if drawn) > enc1 > enc2 > BG_COLOR.
REQ-021 Player drawn SHALL be plyr_visible && !(state==HIT_FLASH && flash_cnt[3]==1) (blink, 8-frame period halves).
REQ-022 GAME_OVER: encounters suppressed; player and background drawn with blue and green forced to 0.
REQ-023 States: PLAYING, HIT_FLASH, GAME_OVER; encoding free.
REQ-024 Collision pixel = visible && plyr_visible && (enc1_visible || enc2_visible); raw plyr_visible, not blink-gated.
REQ-025 PLAYING: a collision pixel SHALL set hit_pending; other states SHALL not set it.
REQ-026 At FS in PLAYING with hit_pending: if lives==1 -> lives=0, GAME_OVER; else lives-=1, flash_cnt=FLASH_FRAMES, HIT_FLASH; hit_pending cleared.
REQ-027 At FS in PLAYING without hit_pending: score+=1, saturating at 0xFFFF.
REQ-028 Collision on the FS pixel itself SHALL set hit_pending for the new frame, after the FS decision (not lost, not double-counted).
REQ-029 HIT_FLASH: at each FS flash_cnt-=1; when it reaches 0 -> PLAYING with hit_pending=0; score not incremented.
REQ-030 GAME_OVER: lives, score frozen; restart -> PLAYING, lives=LIVES, score=0, hit_pending=0 next edge.
REQ-031 restart outside GAME_OVER SHALL be ignored; restart coincident with FS in GAME_OVER takes restart.
REQ-032 At most one life SHALL be lost per frame regardless of number of collision pixels.

Reset
REQ-033 reset==0 SHALL immediately set state=PLAYING, lives=LIVES, score=0, flash_cnt=0, hit_pending=0, vga_*=0, game_over=0.
REQ-034 Reset asserted mid-frame or mid-flash SHALL abort all state; first FS after release counts as a normal PLAYING FS.

Verification
REQ-035 Player only at (100,50), visible=1, colour 0xABC -> vga outputs 0xABC one cycle later; visible=0 -> 0x000.
REQ-036 Player and enc1 overlap for 20 pixels in one frame -> next FS: lives 3->2, HIT_FLASH, flash_cnt=60.
REQ-037 Collisions every frame during HIT_FLASH -> lives stays 2 for 60 FS, then PLAYING; next colliding frame -> lives 1.
REQ-038 Third hit with lives==1 -> lives=0, game_over=1, enc pixels not drawn; restart pulse -> lives=3, score=0, game_over=0.
REQ-039 70000 clean frames (score preloaded near limit via forcing) -> score saturates at 0xFFFF, no wrap.
REQ-040 Collision only at pixel (0,0) of frame k -> no loss at FS k, life lost at FS k+1; reset pulse mid-HIT_FLASH -> all outputs at reset values.
